// File: rtl/rr_hold_arbiter_if.sv
// Request/grant bundle between the requesters and rr_hold_arbiter.
//   in_request      requester -> arbiter, bit i = requester i
//   out_grant       arbiter -> requesters, registered one-hot grant (0 when idle)
//   out_grant_valid high when out_grant != 0
//   out_grant_id    index of the granted requester, 0 when idle
//   out_preempt     one-cycle pulse when a tenure is ended by the hold timeout
// master = requester side, slave = arbiter side.
interface rr_hold_arbiter_if #(
    parameter int N    = 4,
    parameter int ID_W = 2
);
    logic [N-1:0]    in_request;
    logic [N-1:0]    out_grant;
    logic            out_grant_valid;
    logic [ID_W-1:0] out_grant_id;
    logic            out_preempt;

    modport master (
        output in_request,
        input  out_grant,
        input  out_grant_valid,
        input  out_grant_id,
        input  out_preempt
    );

    modport slave (
        input  in_request,
        output out_grant,
        output out_grant_valid,
        output out_grant_id,
        output out_preempt
    );
endinterface

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with bounded grant tenure for one shared resource.
// A requester keeps its grant while its request stays high, for at most
// MAX_HOLD consecutive cycles; handoff to the next requester is zero-bubble.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    rr_hold_arbiter_if.slave (request in; grant/valid/id/preempt out,
//          all registered)
module rr_hold_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 4,
    parameter int ID_W     = (N > 1) ? $clog2(N) : 1,
    parameter int CNT_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1
) (
    input logic              clk,
    input logic              rst_n,
    rr_hold_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic            valid_q, valid_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic            preempt_q, preempt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [N-1:0]    cand;
    logic            hit;
    logic [ID_W-1:0] win;
    int unsigned     idx;
    logic            release_c;
    logic            timeout_c;

    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] i);
        return (i == ID_W'(N - 1)) ? '0 : i + ID_W'(1);
    endfunction

    // Rotating search from ptr_q. The current owner is masked so a tenure
    // that ends always prefers another requester first.
    always_comb begin
        cand = bus.in_request;
        if (state_q == GRANT) begin
            cand[id_q] = 1'b0;
        end
        hit = 1'b0;
        win = '0;
        idx = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!hit && cand[idx[ID_W-1:0]]) begin
                hit = 1'b1;
                win = idx[ID_W-1:0];
            end
        end
    end

    assign release_c = !bus.in_request[id_q];
    assign timeout_c = (cnt_q == CNT_W'(MAX_HOLD - 1));

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        valid_d   = valid_q;
        id_d      = id_q;
        ptr_d     = ptr_q;
        preempt_d = 1'b0;
        cnt_d     = cnt_q;

        case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d      = GRANT;
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    valid_d      = 1'b1;
                    id_d         = win;
                    ptr_d        = next_ptr(win);
                    cnt_d        = '0;
                end
            end
            GRANT: begin
                if (release_c || timeout_c) begin
                    // Release wins over a coincident timeout: no preempt pulse.
                    preempt_d = !release_c;
                    cnt_d     = '0;
                    if (hit) begin
                        grant_d      = '0;
                        grant_d[win] = 1'b1;
                        id_d         = win;
                        ptr_d        = next_ptr(win);
                    end else if (release_c) begin
                        state_d = IDLE;
                        grant_d = '0;
                        valid_d = 1'b0;
                        id_d    = '0;
                    end else begin
                        // Sole requester timed out: re-grant the same owner.
                        ptr_d = next_ptr(id_q);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            id_q      <= '0;
            ptr_q     <= '0;
            preempt_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            valid_q   <= valid_d;
            id_q      <= id_d;
            ptr_q     <= ptr_d;
            preempt_q <= preempt_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.out_grant       = grant_q;
    assign bus.out_grant_valid = valid_q;
    assign bus.out_grant_id    = id_q;
    assign bus.out_preempt     = preempt_q;

endmodule
